// File: rtl/prom_nibble_loader_pkg.sv
// Shared constants for the nibble PROM loader: geometry, FSM encodings and checksum helper.
package prom_nibble_loader_pkg;

  localparam int PROM_DEPTH = 256;
  localparam int PROM_WIDTH = 4;
  localparam int PROM_AW    = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_VERIFY = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic logic [7:0] sum_nibble(input logic [7:0] acc, input logic [PROM_WIDTH-1:0] nib);
    return acc + {4'd0, nib};
  endfunction

endpackage

// File: rtl/prom_nibble_loader_dpram.sv
// 256x4 RAM: port A writes during load and is swept during verify; port B is the game read port.
module dpram_256x4
  import prom_nibble_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_we,
  input  logic [PROM_AW-1:0]    a_addr,
  input  logic [PROM_WIDTH-1:0] a_wdata,
  output logic [PROM_WIDTH-1:0] a_rdata,
  input  logic                  b_en,
  input  logic                  b_clr,
  input  logic [PROM_AW-1:0]    b_addr,
  output logic [PROM_WIDTH-1:0] b_rdata
);

  logic [PROM_WIDTH-1:0] mem_r [PROM_DEPTH];

  // Port A write and registered read
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_r[a_addr] <= a_wdata;
    end
    a_rdata <= mem_r[a_addr];
  end

  // Port B registered read; cleared whenever the image is not being served
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_rdata <= 4'd0;
    end else if (b_clr) begin
      b_rdata <= 4'd0;
    end else if (b_en) begin
      b_rdata <= mem_r[b_addr];
    end else begin
      b_rdata <= b_rdata;
    end
  end

endmodule

// File: rtl/prom_nibble_loader.sv
// Loads a 256x4 PROM image from the ioctl download bus, verifies it by a read sweep, then serves reads.
module prom_nibble_loader
  import prom_nibble_loader_pkg::*;
#(
  parameter logic [7:0]  IMG_INDEX = 8'd0,
  parameter logic [24:0] BASE_ADDR = 25'h000000
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  rd_addr,
  input  logic        rd_cs,
  output logic [3:0]  rd_dout,
  output logic        busy,
  output logic        loaded,
  output logic [7:0]  checksum,
  output logic        error
);

  state_t                state_r;
  state_t                state_s;
  logic                  match_s;
  logic [24:0]           offset_s;
  logic                  in_range_s;
  logic                  enter_load_s;
  logic                  verify_done_s;
  logic                  ram_a_we_s;
  logic [PROM_AW-1:0]    ram_a_addr_s;
  logic [PROM_WIDTH-1:0] ram_a_rdata_s;
  logic                  rd_en_s;
  logic                  rd_clr_s;
  logic [PROM_AW-1:0]    sweep_cnt_r;
  logic                  sweep_done_r;
  logic                  acc_valid_r;
  logic [PROM_DEPTH-1:0] bitmap_r;

  // Next-state, range decode and RAM port steering
  always_comb begin
    match_s       = ioctl_download && (ioctl_index == IMG_INDEX);
    offset_s      = ioctl_addr - BASE_ADDR;
    in_range_s    = (ioctl_addr >= BASE_ADDR) && (offset_s[24:8] == 17'd0);
    verify_done_s = sweep_done_r && acc_valid_r;
    state_s       = state_r;
    case (state_r)
      ST_IDLE:   if (match_s) state_s = ST_LOAD;   else state_s = ST_IDLE;
      ST_LOAD:   if (match_s) state_s = ST_LOAD;   else state_s = ST_VERIFY;
      ST_VERIFY: if (match_s) state_s = ST_LOAD;
                 else if (verify_done_s) state_s = ST_DONE;
                 else state_s = ST_VERIFY;
      ST_DONE:   if (match_s) state_s = ST_LOAD;   else state_s = ST_DONE;
      default:   state_s = ST_IDLE;
    endcase
    enter_load_s = (state_s == ST_LOAD) && (state_r != ST_LOAD);
    ram_a_we_s   = (state_r == ST_LOAD) && ioctl_wr && in_range_s;
    ram_a_addr_s = (state_r == ST_LOAD) ? offset_s[7:0] : sweep_cnt_r;
    // Clearing on the next state keeps rd_dout at zero in every cycle spent outside DONE
    rd_en_s      = (state_r == ST_DONE) && (state_s == ST_DONE) && rd_cs;
    rd_clr_s     = (state_s != ST_DONE);
  end

  // FSM, coverage bitmap, verify sweep and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      sweep_cnt_r  <= 8'd0;
      sweep_done_r <= 1'b0;
      acc_valid_r  <= 1'b0;
      bitmap_r     <= {PROM_DEPTH{1'b0}};
      busy         <= 1'b0;
      loaded       <= 1'b0;
      checksum     <= 8'd0;
      error        <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == ST_LOAD) || (state_s == ST_VERIFY);
      if (enter_load_s) begin
        loaded       <= 1'b0;
        error        <= 1'b0;
        checksum     <= 8'd0;
        bitmap_r     <= {PROM_DEPTH{1'b0}};
        sweep_cnt_r  <= 8'd0;
        sweep_done_r <= 1'b0;
        acc_valid_r  <= 1'b0;
      end else if (state_r == ST_LOAD) begin
        if (ram_a_we_s) begin
          bitmap_r[offset_s[7:0]] <= 1'b1;
          if (ioctl_dout[7:4] != 4'd0) begin
            error <= 1'b1;
          end
        end
        sweep_cnt_r  <= 8'd0;
        sweep_done_r <= 1'b0;
        acc_valid_r  <= 1'b0;
      end else if (state_r == ST_VERIFY) begin
        // Issue stage checks coverage; accumulate stage sees the RAM data one cycle later
        if (!sweep_done_r) begin
          if (!bitmap_r[sweep_cnt_r]) begin
            error <= 1'b1;
          end
          sweep_cnt_r <= sweep_cnt_r + 8'd1;
          if (sweep_cnt_r == 8'hFF) begin
            sweep_done_r <= 1'b1;
          end
        end
        acc_valid_r <= !sweep_done_r;
        if (acc_valid_r) begin
          checksum <= sum_nibble(checksum, ram_a_rdata_s);
        end
        if (state_s == ST_DONE) begin
          loaded <= 1'b1;
        end
      end
    end
  end

  dpram_256x4 u_ram (
    .clk     (clk),
    .reset   (reset),
    .a_we    (ram_a_we_s),
    .a_addr  (ram_a_addr_s),
    .a_wdata (ioctl_dout[3:0]),
    .a_rdata (ram_a_rdata_s),
    .b_en    (rd_en_s),
    .b_clr   (rd_clr_s),
    .b_addr  (rd_addr),
    .b_rdata (rd_dout)
  );

endmodule

// File: tb/tb_prom_nibble_loader.sv
// Directed self-checking bench for prom_nibble_loader (image index 2, base address 0x100).
module tb_prom_nibble_loader;

  localparam logic [7:0]  IMG  = 8'd2;
  localparam logic [24:0] BASE = 25'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  rd_addr;
  logic        rd_cs;
  logic [3:0]  rd_dout;
  logic        busy;
  logic        loaded;
  logic [7:0]  checksum;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   img [256];
  logic [255:0] no_skip = 256'd0;
  logic [255:0] skip_ff = {1'b1, 255'd0};

  prom_nibble_loader #(.IMG_INDEX(IMG), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .rd_addr(rd_addr), .rd_cs(rd_cs), .rd_dout(rd_dout), .busy(busy), .loaded(loaded),
    .checksum(checksum), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern;
    for (int i = 0; i < 256; i++) img[i] = 8'(i) & 8'h0F;
  endtask

  task automatic set_const(input logic [7:0] v);
    for (int i = 0; i < 256; i++) img[i] = v;
  endtask

  task automatic dl_begin(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick;
    ioctl_wr = 1'b0;
  endtask

  task automatic send_image(input logic [255:0] skip);
    for (int i = 0; i < 256; i++) begin
      if (!skip[i]) send_byte(BASE + 25'(i), img[i]);
    end
  endtask

  task automatic wait_loaded(output int n);
    n = 0;
    while (loaded !== 1'b1 && n < 400) begin
      tick;
      n++;
    end
    n_cmp++;
    if (n >= 400) begin n_bad++; $display("FAIL load_timeout: loaded=%b after %0d cycles, required 1", loaded, n); end
  endtask

  task automatic read_at(input logic [7:0] a);
    rd_addr = a;
    rd_cs = 1'b1;
    tick;
    rd_cs = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    n_cmp++; if ({rd_dout, busy, loaded, checksum, error} !== 15'd0) begin n_bad++;
      $display("FAIL reset_state: rd_dout=%h busy=%b loaded=%b checksum=%h error=%b, required all 0", rd_dout, busy, loaded, checksum, error); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic_load;
    int n;
    set_pattern();
    dl_begin(IMG);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_on_load: got %b required 1", busy); end
    send_image(no_skip);
    ioctl_download = 1'b0;
    wait_loaded(n);
    n_cmp++; if (n !== 258) begin n_bad++; $display("FAIL verify_latency: got %0d cycles required 258", n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_done: got %b required 0", busy); end
    n_cmp++; if (checksum !== 8'h80) begin n_bad++; $display("FAIL basic_checksum: got %h required 80", checksum); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b required 0", error); end
    read_at(8'h16);
    n_cmp++; if (rd_dout !== 4'h6) begin n_bad++; $display("FAIL read_16: got %h required 6", rd_dout); end
    rd_addr = 8'h17;
    tick;
    n_cmp++; if (rd_dout !== 4'h6) begin n_bad++; $display("FAIL read_hold: got %h required 6", rd_dout); end
  endtask

  task automatic test_upper_nibble;
    int n;
    set_pattern();
    img[8'h45] = 8'hAF;
    dl_begin(IMG);
    send_image(no_skip);
    ioctl_download = 1'b0;
    wait_loaded(n);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL upper_nibble_error: got %b required 1", error); end
    n_cmp++; if (checksum !== 8'h8A) begin n_bad++; $display("FAIL upper_nibble_checksum: got %h required 8a", checksum); end
    read_at(8'h45);
    n_cmp++; if (rd_dout !== 4'hF) begin n_bad++; $display("FAIL upper_nibble_read: got %h required f", rd_dout); end
  endtask

  task automatic test_coverage_gap;
    int n;
    set_const(8'h00);
    dl_begin(IMG);
    send_image(no_skip);
    ioctl_download = 1'b0;
    wait_loaded(n);
    n_cmp++; if ({checksum, error} !== 9'd0) begin n_bad++; $display("FAIL zero_load: checksum=%h error=%b required 00/0", checksum, error); end
    set_pattern();
    dl_begin(IMG);
    send_image(skip_ff);
    ioctl_download = 1'b0;
    wait_loaded(n);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL gap_error: got %b required 1", error); end
    n_cmp++; if (checksum !== 8'h71) begin n_bad++; $display("FAIL gap_checksum: got %h required 71", checksum); end
  endtask

  task automatic test_wrong_index;
    read_at(8'h23);
    n_cmp++; if (rd_dout !== 4'h3) begin n_bad++; $display("FAIL pre_wrong_read: got %h required 3", rd_dout); end
    set_const(8'h05);
    dl_begin(IMG + 8'd1);
    send_image(no_skip);
    ioctl_download = 1'b0;
    tick;
    n_cmp++; if ({busy, loaded} !== 2'b01) begin n_bad++; $display("FAIL wrong_idx_done: busy=%b loaded=%b required 0/1", busy, loaded); end
    read_at(8'h23);
    n_cmp++; if (rd_dout !== 4'h3) begin n_bad++; $display("FAIL wrong_idx_ram: got %h required 3", rd_dout); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    rd_addr = 8'h23;
    rd_cs = 1'b1;
    dl_begin(IMG + 8'd1);
    send_image(no_skip);
    ioctl_download = 1'b0;
    tick;
    n_cmp++; if ({busy, loaded, rd_dout} !== 6'd0) begin n_bad++;
      $display("FAIL wrong_idx_idle: busy=%b loaded=%b rd_dout=%h required 0", busy, loaded, rd_dout); end
    rd_cs = 1'b0;
  endtask

  task automatic test_out_of_range;
    int n;
    set_pattern();
    dl_begin(IMG);
    send_image(skip_ff);
    send_byte(BASE - 25'd1, 8'h0C);
    send_byte(BASE + 25'd256, 8'h0D);
    ioctl_download = 1'b0;
    wait_loaded(n);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL oor_bitmap: error=%b required 1", error); end
    n_cmp++; if (checksum !== 8'h71) begin n_bad++; $display("FAIL oor_checksum: got %h required 71", checksum); end
    read_at(8'h00);
    n_cmp++; if (rd_dout !== 4'h0) begin n_bad++; $display("FAIL oor_read_00: got %h required 0", rd_dout); end
    read_at(8'hFF);
    n_cmp++; if (rd_dout !== 4'h0) begin n_bad++; $display("FAIL oor_read_ff: got %h required 0", rd_dout); end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    set_pattern();
    dl_begin(IMG);
    send_image(no_skip);
    ioctl_download = 1'b0;
    for (int i = 0; i < 101; i++) tick;
    reset = 1'b1;
    #1;
    n_cmp++; if ({rd_dout, busy, loaded, checksum, error} !== 15'd0) begin n_bad++;
      $display("FAIL mid_sweep_reset: rd_dout=%h busy=%b loaded=%b checksum=%h error=%b, required 0", rd_dout, busy, loaded, checksum, error); end
    tick;
    reset = 1'b0;
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: busy=%b required 0", busy); end
    dl_begin(IMG);
    send_image(no_skip);
    ioctl_download = 1'b0;
    wait_loaded(n);
    n_cmp++; if ({checksum, error} !== {8'h80, 1'b0}) begin n_bad++; $display("FAIL reload: checksum=%h error=%b required 80/0", checksum, error); end
    read_at(8'h16);
    n_cmp++; if (rd_dout !== 4'h6) begin n_bad++; $display("FAIL reload_read: got %h required 6", rd_dout); end
    dl_begin(IMG);
    n_cmp++; if ({loaded, busy, rd_dout} !== 6'b010000) begin n_bad++;
      $display("FAIL redownload_drop: loaded=%b busy=%b rd_dout=%h required 0/1/0", loaded, busy, rd_dout); end
    ioctl_download = 1'b0;
    wait_loaded(n);
    n_cmp++; if ({checksum, error} !== {8'h80, 1'b1}) begin n_bad++; $display("FAIL empty_load: checksum=%h error=%b required 80/1", checksum, error); end
  endtask

  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = 25'd0;
    ioctl_dout = 8'd0;
    rd_addr = 8'd0;
    rd_cs = 1'b0;
    test_reset();
    test_basic_load();
    test_upper_nibble();
    test_coverage_gap();
    test_wrong_index();
    test_out_of_range();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
